// File: rtl/bash_pkg.sv
// -----------------------------------------------------------------------------
// bash_pkg
// Shared constants and types for the bash line port: buffer depth, the ASCII
// codes the line editor reacts to, the port state enum and a printable test.
// -----------------------------------------------------------------------------
package bash_pkg;

  // Line buffer entries, including the 0x00 terminator.
  localparam int MAX_LEN = 32;

  localparam logic [7:0] NUL      = 8'h00;
  localparam logic [7:0] BS       = 8'h08;
  localparam logic [7:0] LF       = 8'h0A;
  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    ST_EDIT,
    ST_SEND,
    ST_RUN,
    ST_DONE
  } bash_state_t;

  function automatic logic is_print(input logic [7:0] c);
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

endpackage

// File: rtl/bash_line_buf.sv
// -----------------------------------------------------------------------------
// bash_line_buf
// Line storage for the bash line port: DEPTH x 8 bit array with one
// synchronous write port and one combinational read port.
//   clk        : clock
//   i_wr_en    : write strobe
//   i_wr_idx   : write index
//   i_wr_data  : write data
//   i_rd_idx   : read index
//   o_rd_data  : data at i_rd_idx (combinational)
// -----------------------------------------------------------------------------
module bash_line_buf
  import bash_pkg::*;
#(
  parameter int DEPTH = MAX_LEN,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_idx,
  input  logic [7:0]    i_wr_data,
  input  logic [AW-1:0] i_rd_idx,
  output logic [7:0]    o_rd_data
);

  // Contents are not reset: only entries below the committed length are
  // ever read back, and each of those is written before the commit.
  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/bash_line_port.sv
// -----------------------------------------------------------------------------
// bash_line_port
// Terminal-side endpoint of the bash line protocol. Keyboard characters are
// edited into a line buffer with local echo; on Enter the committed line is
// served to the command one character per lineOut_nextASCII, then the
// command's output is streamed to the screen until in_solved, acknowledged by
// a one-cycle out_solved.
//   clk, rst            : clock, synchronous active-high reset
//   key_valid/key_ascii : keyboard strobe and character
//   key_drop            : pulse, keystroke discarded
//   scr_valid/scr_char  : pending screen character
//   scr_ready           : screen writer accepts
//   out_newASCII_ready  : line is being served
//   out_lineLen         : committed length incl. terminator
//   lineOut             : current served character
//   lineOut_nextASCII   : command consumed lineOut
//   in_newASCII_ready   : command has an output character on lineIn
//   lineIn_nextASCII    : pulse, lineIn taken this cycle
//   in_solved           : command finished
//   out_solved          : one-cycle acknowledge
// -----------------------------------------------------------------------------
module bash_line_port
  import bash_pkg::*;
#(
  parameter int MAX_LEN = bash_pkg::MAX_LEN,
  parameter int GAP     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_ascii,
  output logic       key_drop,
  output logic       scr_valid,
  output logic [7:0] scr_char,
  input  logic       scr_ready,
  output logic       out_newASCII_ready,
  output logic [5:0] out_lineLen,
  output logic [7:0] lineOut,
  input  logic       lineOut_nextASCII,
  input  logic       in_newASCII_ready,
  input  logic [7:0] lineIn,
  output logic       lineIn_nextASCII,
  input  logic       in_solved,
  output logic       out_solved
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int CW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  bash_state_t r_state;
  bash_state_t w_state_next;

  logic [5:0]    r_len;
  logic [5:0]    r_rd_idx;
  logic [5:0]    r_line_len;
  logic          r_scr_valid;
  logic [7:0]    r_scr_char;
  logic          r_key_drop;
  logic [CW-1:0] r_cool;
  logic          r_solved_pend;

  logic       w_key_drop;
  logic       w_echo;
  logic [7:0] w_echo_char;
  logic       w_wr_en;
  logic [7:0] w_wr_data;
  logic       w_len_inc;
  logic       w_len_dec;
  logic       w_commit;
  logic       w_rd_adv;
  logic       w_take;
  logic       w_solved;
  logic [7:0] w_rd_data;

  bash_line_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (r_len[AW-1:0]),
    .i_wr_data (w_wr_data),
    .i_rd_idx  (r_rd_idx[AW-1:0]),
    .o_rd_data (w_rd_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EDIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and per-cycle control strobes
  always_comb begin
    w_state_next = r_state;
    w_key_drop   = 1'b0;
    w_echo       = 1'b0;
    w_echo_char  = NUL;
    w_wr_en      = 1'b0;
    w_wr_data    = NUL;
    w_len_inc    = 1'b0;
    w_len_dec    = 1'b0;
    w_commit     = 1'b0;
    w_rd_adv     = 1'b0;
    w_take       = 1'b0;
    w_solved     = 1'b0;

    unique case (r_state)
      ST_EDIT: begin
        if (key_valid) begin
          // Echo is single-entry: a key arriving while the previous echo
          // is still pending cannot be shown, so it is discarded.
          if (r_scr_valid) begin
            w_key_drop = 1'b1;
          end else if (is_print(key_ascii)) begin
            if (r_len < 6'(MAX_LEN - 1)) begin
              w_wr_en     = 1'b1;
              w_wr_data   = key_ascii;
              w_len_inc   = 1'b1;
              w_echo      = 1'b1;
              w_echo_char = key_ascii;
            end else begin
              w_key_drop = 1'b1;
            end
          end else if (key_ascii == BS) begin
            if (r_len != 6'd0) begin
              w_len_dec   = 1'b1;
              w_echo      = 1'b1;
              w_echo_char = BS;
            end
          end else if ((key_ascii == CR) || (key_ascii == LF)) begin
            w_wr_en      = 1'b1;
            w_wr_data    = NUL;
            w_commit     = 1'b1;
            w_echo       = 1'b1;
            w_echo_char  = LF;
            w_state_next = ST_SEND;
          end
        end
      end

      ST_SEND: begin
        w_key_drop = key_valid;
        if (lineOut_nextASCII) begin
          // The terminator is the last entry; do not step past it.
          if (r_rd_idx == (r_line_len - 6'd1)) begin
            w_state_next = ST_RUN;
          end else begin
            w_rd_adv = 1'b1;
          end
        end
      end

      ST_RUN: begin
        w_key_drop = key_valid;
        if (in_solved || r_solved_pend) begin
          w_state_next = ST_DONE;
        end else if (in_newASCII_ready && (r_cool == '0) && !r_scr_valid) begin
          w_take = 1'b1;
          if (lineIn != NUL) begin
            w_echo      = 1'b1;
            w_echo_char = lineIn;
          end
        end
      end

      ST_DONE: begin
        w_key_drop = key_valid;
        // Hold the acknowledge until the last output character is on screen.
        if (!r_scr_valid) begin
          w_solved     = 1'b1;
          w_state_next = ST_EDIT;
        end
      end

      default: w_state_next = ST_EDIT;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len         <= 6'd0;
      r_rd_idx      <= 6'd0;
      r_line_len    <= 6'd0;
      r_scr_valid   <= 1'b0;
      r_scr_char    <= NUL;
      r_key_drop    <= 1'b0;
      r_cool        <= '0;
      r_solved_pend <= 1'b0;
    end else begin
      r_key_drop <= w_key_drop;

      // New echo is only produced when nothing is pending, so load and
      // handshake never collide.
      if (w_echo) begin
        r_scr_valid <= 1'b1;
        r_scr_char  <= w_echo_char;
      end else if (r_scr_valid && scr_ready) begin
        r_scr_valid <= 1'b0;
      end

      if (w_len_inc) begin
        r_len <= r_len + 6'd1;
      end else if (w_len_dec) begin
        r_len <= r_len - 6'd1;
      end else if (w_solved) begin
        r_len <= 6'd0;
      end

      if (w_commit) begin
        r_line_len <= r_len + 6'd1;
        r_rd_idx   <= 6'd0;
      end else if (w_rd_adv) begin
        r_rd_idx <= r_rd_idx + 6'd1;
      end else if (w_solved) begin
        r_rd_idx <= 6'd0;
      end

      // Cooldown masks a command ready that lags its own index update.
      if (w_take) begin
        r_cool <= CW'(GAP);
      end else if (r_cool != '0) begin
        r_cool <= r_cool - 1'b1;
      end

      // A finish seen while the line is still being served is honoured
      // as soon as RUN is entered.
      if ((r_state == ST_SEND) && in_solved) begin
        r_solved_pend <= 1'b1;
      end else if ((r_state == ST_RUN) && (w_state_next == ST_DONE)) begin
        r_solved_pend <= 1'b0;
      end
    end
  end

  assign key_drop           = r_key_drop;
  assign scr_valid          = r_scr_valid;
  assign scr_char           = r_scr_char;
  assign out_newASCII_ready = (r_state == ST_SEND);
  assign out_lineLen        = r_line_len;
  // Buffer contents are not reset, so the read port is only exposed while serving.
  assign lineOut            = (r_state == ST_SEND) ? w_rd_data : NUL;
  assign lineIn_nextASCII   = w_take;
  assign out_solved         = w_solved;

endmodule

// File: tb/tb_bash_line_port.sv
module tb_bash_line_port;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [7:0] key_ascii;
  logic       key_drop;
  logic       scr_valid;
  logic [7:0] scr_char;
  logic       scr_ready;
  logic       out_newASCII_ready;
  logic [5:0] out_lineLen;
  logic [7:0] lineOut;
  logic       lineOut_nextASCII;
  logic       in_newASCII_ready;
  logic [7:0] lineIn;
  logic       lineIn_nextASCII;
  logic       in_solved;
  logic       out_solved;

  int tests = 0;
  int fails = 0;

  logic [63:0] scr_hist;
  int          scr_n;
  int          drop_cnt = 0;
  logic [7:0]  cmd_str [0:2];

  bash_line_port dut (
    .clk                (clk),
    .rst                (rst),
    .key_valid          (key_valid),
    .key_ascii          (key_ascii),
    .key_drop           (key_drop),
    .scr_valid          (scr_valid),
    .scr_char           (scr_char),
    .scr_ready          (scr_ready),
    .out_newASCII_ready (out_newASCII_ready),
    .out_lineLen        (out_lineLen),
    .lineOut            (lineOut),
    .lineOut_nextASCII  (lineOut_nextASCII),
    .in_newASCII_ready  (in_newASCII_ready),
    .lineIn             (lineIn),
    .lineIn_nextASCII   (lineIn_nextASCII),
    .in_solved          (in_solved),
    .out_solved         (out_solved)
  );

  always #5 clk = ~clk;

  // Screen writer and drop counter, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (scr_valid && scr_ready) begin
        scr_hist = {scr_hist[55:0], scr_char};
        scr_n++;
      end
      if (key_drop) drop_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] c);
    key_valid = 1'b1;
    key_ascii = c;
    step();
    key_valid = 1'b0;
    key_ascii = 8'h00;
    step();
  endtask

  task automatic press_enter();
    key_valid = 1'b1;
    key_ascii = 8'h0D;
    step();
    key_valid = 1'b0;
    key_ascii = 8'h00;
  endtask

  task automatic serve(input int n);
    repeat (n) begin
      lineOut_nextASCII = 1'b1;
      step();
      lineOut_nextASCII = 1'b0;
    end
  endtask

  task automatic finish_cmd();
    in_solved = 1'b1;
    step();
    in_solved = 1'b0;
    step();
  endtask

  task automatic clear_scr();
    scr_hist = 64'h0;
    scr_n    = 0;
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    rst = 1'b1;
    step();
    step();
    outs = {out_newASCII_ready, lineOut, out_lineLen, scr_valid, scr_char,
            key_drop, lineIn_nextASCII, out_solved};
    tests++;
    if (outs !== 32'h0) begin
      $display("FAIL reset_outputs: got %h expected 0", outs); fails++;
    end
    rst = 1'b0;
    step();
    $display("[TB] reset checked");
  endtask

  task automatic test_ls();
    logic [7:0] exp_line [0:2];
    exp_line[0] = 8'h6C; exp_line[1] = 8'h73; exp_line[2] = 8'h00;
    clear_scr();
    press(8'h6C);
    press(8'h73);
    press_enter();
    tests++;
    if (out_newASCII_ready !== 1'b1) begin
      $display("FAIL ls_ready_after_enter: got %b expected 1", out_newASCII_ready); fails++;
    end
    tests++;
    if (out_lineLen !== 6'd3) begin
      $display("FAIL ls_lineLen: got %0d expected 3", out_lineLen); fails++;
    end
    step();
    tests++;
    if (scr_n != 3 || scr_hist !== 64'h6C730A) begin
      $display("FAIL ls_screen: got n=%0d %h expected n=3 6c730a", scr_n, scr_hist); fails++;
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (lineOut !== exp_line[i] || out_newASCII_ready !== 1'b1) begin
        $display("FAIL ls_lineOut%0d: got %h rdy=%b expected %h rdy=1", i, lineOut,
                 out_newASCII_ready, exp_line[i]); fails++;
      end
      serve(1);
    end
    tests++;
    if (out_newASCII_ready !== 1'b0) begin
      $display("FAIL ls_ready_drop: got %b expected 0", out_newASCII_ready); fails++;
    end
    in_solved = 1'b1;
    step();
    in_solved = 1'b0;
    tests++;
    if (out_solved !== 1'b1) begin
      $display("FAIL ls_out_solved: got %b expected 1", out_solved); fails++;
    end
    step();
    tests++;
    if (out_solved !== 1'b0) begin
      $display("FAIL ls_out_solved_pulse: got %b expected 0", out_solved); fails++;
    end
    $display("[TB] ls line served");
  endtask

  task automatic test_edit();
    logic [7:0] exp_line [0:3];
    exp_line[0] = 8'h61; exp_line[1] = 8'h62; exp_line[2] = 8'h64; exp_line[3] = 8'h00;
    clear_scr();
    press(8'h61);
    press(8'h62);
    press(8'h63);
    press(8'h08);
    press(8'h64);
    press_enter();
    step();
    tests++;
    if (scr_n != 6 || scr_hist !== 64'h6162_6308_640A) begin
      $display("FAIL edit_screen: got n=%0d %h expected n=6 61626308640a", scr_n, scr_hist); fails++;
    end
    tests++;
    if (out_lineLen !== 6'd4) begin
      $display("FAIL edit_lineLen: got %0d expected 4", out_lineLen); fails++;
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (lineOut !== exp_line[i]) begin
        $display("FAIL edit_lineOut%0d: got %h expected %h", i, lineOut, exp_line[i]); fails++;
      end
      serve(1);
    end
    finish_cmd();
    $display("[TB] edit with backspace served");
  endtask

  task automatic test_full();
    int d0;
    d0 = drop_cnt;
    for (int i = 0; i < 35; i++) press(8'(65 + (i % 26)));
    press_enter();
    step();
    tests++;
    if (drop_cnt - d0 != 4) begin
      $display("FAIL full_drops: got %0d expected 4", drop_cnt - d0); fails++;
    end
    tests++;
    if (out_lineLen !== 6'd32) begin
      $display("FAIL full_lineLen: got %0d expected 32", out_lineLen); fails++;
    end
    tests++;
    if (lineOut !== 8'h41) begin
      $display("FAIL full_first: got %h expected 41", lineOut); fails++;
    end
    serve(30);
    tests++;
    if (lineOut !== 8'h45) begin
      $display("FAIL full_idx30: got %h expected 45", lineOut); fails++;
    end
    serve(1);
    tests++;
    if (lineOut !== 8'h00 || out_newASCII_ready !== 1'b1) begin
      $display("FAIL full_terminator: got %h rdy=%b expected 00 rdy=1", lineOut, out_newASCII_ready); fails++;
    end
    serve(1);
    tests++;
    if (out_newASCII_ready !== 1'b0) begin
      $display("FAIL full_ready_drop: got %b expected 0", out_newASCII_ready); fails++;
    end
    finish_cmd();
    $display("[TB] full line served");
  endtask

  task automatic test_run();
    int  idx, h1, h2, pulses, last, min_gap, sol;
    logic took;
    cmd_str[0] = 8'h68; cmd_str[1] = 8'h69; cmd_str[2] = 8'h00;
    press(8'h65);
    press_enter();
    step();
    serve(2);
    clear_scr();
    idx = 0; h1 = 0; h2 = 0; pulses = 0; last = -100; min_gap = 1000;
    // Command whose registered ready reflects its index from two cycles back
    for (int c = 0; c < 20; c++) begin
      in_newASCII_ready = (h2 < 3);
      lineIn = (idx < 3) ? cmd_str[idx] : 8'h00;
      #1;
      took = lineIn_nextASCII;
      if (took) begin
        pulses++;
        if (c - last < min_gap) min_gap = c - last;
        last = c;
      end
      @(posedge clk);
      #1;
      h2 = h1;
      h1 = idx;
      if (took) idx++;
    end
    in_newASCII_ready = 1'b0;
    lineIn = 8'h00;
    tests++;
    if (pulses != 3) begin
      $display("FAIL run_pulses: got %0d expected 3", pulses); fails++;
    end
    tests++;
    if (min_gap < 3) begin
      $display("FAIL run_spacing: got %0d expected >=3", min_gap); fails++;
    end
    tests++;
    if (scr_n != 2 || scr_hist !== 64'h6869) begin
      $display("FAIL run_screen: got n=%0d %h expected n=2 6869", scr_n, scr_hist); fails++;
    end
    sol = 0;
    in_solved = 1'b1;
    step();
    in_solved = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (out_solved) sol++;
      step();
    end
    tests++;
    if (sol != 1) begin
      $display("FAIL run_out_solved: got %0d pulses expected 1", sol); fails++;
    end
    $display("[TB] run output streamed");
  endtask

  task automatic test_backpressure();
    int  d0, sol;
    logic stable;
    press(8'h65);
    press_enter();
    step();
    serve(2);
    clear_scr();
    scr_ready = 1'b0;
    in_newASCII_ready = 1'b1;
    lineIn = 8'h5A;
    #1;
    tests++;
    if (lineIn_nextASCII !== 1'b1) begin
      $display("FAIL bp_take: got %b expected 1", lineIn_nextASCII); fails++;
    end
    @(posedge clk);
    #1;
    in_newASCII_ready = 1'b0;
    lineIn = 8'h00;
    in_solved = 1'b1;
    step();
    in_solved = 1'b0;
    d0 = drop_cnt;
    stable = 1'b1;
    sol = 0;
    for (int c = 0; c < 10; c++) begin
      if (scr_char !== 8'h5A || scr_valid !== 1'b1) stable = 1'b0;
      if (out_solved) sol++;
      key_valid = (c == 3);
      key_ascii = (c == 3) ? 8'h71 : 8'h00;
      step();
    end
    key_valid = 1'b0;
    tests++;
    if (stable !== 1'b1) begin
      $display("FAIL bp_stable: got %b expected 1", stable); fails++;
    end
    tests++;
    if (sol != 0) begin
      $display("FAIL bp_deferred: got %0d solved pulses expected 0", sol); fails++;
    end
    tests++;
    if (drop_cnt - d0 != 1) begin
      $display("FAIL bp_key_drop: got %0d expected 1", drop_cnt - d0); fails++;
    end
    scr_ready = 1'b1;
    #1;
    tests++;
    if (out_solved !== 1'b0) begin
      $display("FAIL bp_solved_early: got %b expected 0", out_solved); fails++;
    end
    step();
    tests++;
    if (out_solved !== 1'b1) begin
      $display("FAIL bp_solved_after: got %b expected 1", out_solved); fails++;
    end
    step();
    tests++;
    if (scr_n != 1 || scr_hist !== 64'h5A) begin
      $display("FAIL bp_screen: got n=%0d %h expected n=1 5a", scr_n, scr_hist); fails++;
    end
    $display("[TB] backpressure checked");
  endtask

  task automatic test_reset_mid();
    logic [31:0] outs;
    press(8'h61);
    press(8'h62);
    scr_ready = 1'b0;
    press_enter();
    step();
    serve(1);
    rst = 1'b1;
    step();
    outs = {out_newASCII_ready, lineOut, out_lineLen, scr_valid, scr_char,
            key_drop, lineIn_nextASCII, out_solved};
    tests++;
    if (outs !== 32'h0) begin
      $display("FAIL rst_mid_outputs: got %h expected 0", outs); fails++;
    end
    rst = 1'b0;
    scr_ready = 1'b1;
    step();
    clear_scr();
    press(8'h78);
    press_enter();
    step();
    tests++;
    if (out_lineLen !== 6'd2 || lineOut !== 8'h78 || out_newASCII_ready !== 1'b1) begin
      $display("FAIL rst_mid_reline: got len=%0d %h rdy=%b expected len=2 78 rdy=1",
               out_lineLen, lineOut, out_newASCII_ready); fails++;
    end
    tests++;
    if (scr_n != 2 || scr_hist !== 64'h780A) begin
      $display("FAIL rst_mid_screen: got n=%0d %h expected n=2 780a", scr_n, scr_hist); fails++;
    end
    serve(2);
    finish_cmd();
    $display("[TB] reset mid-send checked");
  endtask

  initial begin
    rst = 1'b1;
    key_valid = 1'b0;
    key_ascii = 8'h00;
    scr_ready = 1'b1;
    lineOut_nextASCII = 1'b0;
    in_newASCII_ready = 1'b0;
    lineIn = 8'h00;
    in_solved = 1'b0;
    scr_hist = 64'h0;
    scr_n = 0;
    test_reset();
    test_ls();
    test_edit();
    test_full();
    test_run();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
